// File: rtl/hh_membrane_update_if.sv
// Start/done handshake bundle for the Hodgkin-Huxley membrane integrator.
// The integrator takes the slave side and the requester takes the master side.
interface hh_membrane_update_if;
   logic               start;
   logic signed [15:0] m;
   logic signed [15:0] h;
   logic signed [15:0] n;
   logic signed [15:0] i_ext;
   logic        [15:0] dt;
   logic signed [31:0] v_uv;
   logic signed [15:0] v_mv;
   logic               busy;
   logic               done;

   modport master (
      output start, m, h, n, i_ext, dt,
      input  v_uv, v_mv, busy, done
   );

   modport slave (
      input  start, m, h, n, i_ext, dt,
      output v_uv, v_mv, busy, done
   );
endinterface

// File: rtl/hh_membrane_update.sv
// Forward-Euler Hodgkin-Huxley membrane step: one shared multiplier, one
// operation per cycle, 13 cycles from accepted start to the done pulse.
module hh_membrane_update #(
   parameter int G_NA      = 1200,
   parameter int G_K       = 360,
   parameter int G_L       = 3,
   parameter int E_NA      = 50,
   parameter int E_K       = -77,
   parameter int E_L       = -54,
   parameter int V_REST_UV = -65000,
   parameter int V_MIN_UV  = -100000,
   parameter int V_MAX_UV  = 60000
) (
   input  logic                 clk,
   input  logic                 reset,
   hh_membrane_update_if.slave  bus
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_M2, ST_M3, ST_MH, ST_NA1, ST_NA2, ST_N2,
      ST_N4, ST_K1, ST_K2, ST_L, ST_SUM, ST_UPD, ST_DONE
   } state_t;

   localparam logic signed [47:0] C_G_NA  = 48'(G_NA);
   localparam logic signed [47:0] C_G_K   = 48'(G_K);
   localparam logic signed [47:0] C_G_L   = 48'(G_L);
   localparam logic signed [47:0] E_NA_UV = 48'(E_NA * 1000);
   localparam logic signed [47:0] E_K_UV  = 48'(E_K * 1000);
   localparam logic signed [47:0] E_L_UV  = 48'(E_L * 1000);
   localparam logic signed [47:0] V_MIN   = 48'(V_MIN_UV);
   localparam logic signed [47:0] V_MAX   = 48'(V_MAX_UV);
   localparam logic signed [47:0] D10     = 48'sd10;
   localparam logic signed [47:0] D1000   = 48'sd1000;
   localparam logic signed [47:0] D10000  = 48'sd10000;
   localparam logic signed [31:0] V_REST  = 32'(V_REST_UV);
   localparam logic signed [15:0] V_REST_MV = 16'(V_REST_UV / 1000);

   state_t state, state_next;

   logic signed [15:0] gm, gh, gn, iext_r;
   logic        [15:0] dt_r;
   logic signed [31:0] v_r, v_new, v_clamped, v_uv_r;
   logic signed [15:0] v_mv_r;
   logic               busy_r, done_r;
   logic signed [47:0] p, q, t, i_na, i_k, i_l, i_ion;
   logic signed [47:0] mul_a, mul_b, prod, v_ext, v_sum;

   function automatic logic signed [15:0] clamp_gate(input logic signed [15:0] x);
      if (x < 16'sd0)    return '0;
      if (x > 16'sd1000) return 16'sd1000;
      return x;
   endfunction

   assign bus.v_uv = v_uv_r;
   assign bus.v_mv = v_mv_r;
   assign bus.busy = busy_r;
   assign bus.done = done_r;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (bus.start) state_next = ST_M2;
         ST_M2:   state_next = ST_M3;
         ST_M3:   state_next = ST_MH;
         ST_MH:   state_next = ST_NA1;
         ST_NA1:  state_next = ST_NA2;
         ST_NA2:  state_next = ST_N2;
         ST_N2:   state_next = ST_N4;
         ST_N4:   state_next = ST_K1;
         ST_K1:   state_next = ST_K2;
         ST_K2:   state_next = ST_L;
         ST_L:    state_next = ST_SUM;
         ST_SUM:  state_next = ST_UPD;
         ST_UPD:  state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Operand select for the single shared multiplier.
   always_comb begin
      v_ext = 48'(v_r);
      mul_a = '0;
      mul_b = '0;
      case (state)
         ST_M2:  begin mul_a = 48'(gm); mul_b = 48'(gm);            end
         ST_M3:  begin mul_a = p;       mul_b = 48'(gm);            end
         ST_MH:  begin mul_a = p;       mul_b = 48'(gh);            end
         ST_NA1: begin mul_a = p;       mul_b = C_G_NA;             end
         ST_NA2: begin mul_a = t;       mul_b = v_ext - E_NA_UV;    end
         ST_N2:  begin mul_a = 48'(gn); mul_b = 48'(gn);            end
         ST_N4:  begin mul_a = q;       mul_b = q;                  end
         ST_K1:  begin mul_a = q;       mul_b = C_G_K;              end
         ST_K2:  begin mul_a = t;       mul_b = v_ext - E_K_UV;     end
         ST_L:   begin mul_a = C_G_L;   mul_b = v_ext - E_L_UV;     end
         ST_UPD: begin
            mul_a = 48'(iext_r) * D10 - i_ion;
            mul_b = $signed({32'd0, dt_r});
         end
         default: ;
      endcase
      prod  = mul_a * mul_b;
      v_sum = v_ext + prod / D1000;
      if (v_sum < V_MIN)      v_clamped = 32'(V_MIN);
      else if (v_sum > V_MAX) v_clamped = 32'(V_MAX);
      else                    v_clamped = 32'(v_sum);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gm     <= '0;
         gh     <= '0;
         gn     <= '0;
         iext_r <= '0;
         dt_r   <= '0;
         v_r    <= '0;
         v_new  <= '0;
         p      <= '0;
         q      <= '0;
         t      <= '0;
         i_na   <= '0;
         i_k    <= '0;
         i_l    <= '0;
         i_ion  <= '0;
         v_uv_r <= V_REST;
         v_mv_r <= V_REST_MV;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_next != ST_IDLE);
         done_r <= (state == ST_DONE);
         case (state)
            ST_IDLE: if (bus.start) begin
               gm     <= clamp_gate(bus.m);
               gh     <= clamp_gate(bus.h);
               gn     <= clamp_gate(bus.n);
               iext_r <= bus.i_ext;
               dt_r   <= bus.dt;
               v_r    <= v_uv_r;
            end
            ST_M2, ST_M3, ST_MH: p <= prod / D1000;
            ST_NA1, ST_K1:       t <= prod;
            ST_NA2:              i_na <= prod / D10000;
            ST_N2, ST_N4:        q <= prod / D1000;
            ST_K2:               i_k <= prod / D10000;
            ST_L:                i_l <= prod / D10;
            ST_SUM:              i_ion <= i_na + i_k + i_l;
            ST_UPD:              v_new <= v_clamped;
            ST_DONE: begin
               v_uv_r <= v_new;
               v_mv_r <= 16'(v_new / 32'sd1000);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_hh_membrane_update.sv
// Scoreboarded random and directed bench for hh_membrane_update against a
// plain-arithmetic Euler-step model.
module tb_hh_membrane_update;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;
   longint model_v = -65000;
   longint exp_v_q[$];
   int     exp_k_q[$];
   logic   prev_done = 1'b0;
   longint last_v = -65000;

   hh_membrane_update_if bus ();

   hh_membrane_update dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic longint clampl(input longint x, input longint lo, input longint hi);
      return (x < lo) ? lo : ((x > hi) ? hi : x);
   endfunction

   // Reference Euler step straight from the membrane equations.
   function automatic longint model_step(input longint v, input longint m, input longint h,
                                         input longint n, input longint iext, input longint dt);
      longint gm, gh, gn, m3h, n4, i_na, i_k, i_l, dv;
      gm   = clampl(m, 0, 1000);
      gh   = clampl(h, 0, 1000);
      gn   = clampl(n, 0, 1000);
      m3h  = ((gm * gm / 1000) * gm / 1000) * gh / 1000;
      n4   = (gn * gn / 1000) * (gn * gn / 1000) / 1000;
      i_na = m3h * 1200 * (v - 50000) / 10000;
      i_k  = n4 * 360 * (v + 77000) / 10000;
      i_l  = 3 * (v + 54000) / 10;
      dv   = (iext * 10 - (i_na + i_k + i_l)) * dt / 1000;
      return clampl(v + dv, -100000, 60000);
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         prev_done = 1'b0;
         last_v = -65000;
      end else begin
         if (bus.done) begin
            check("done_one_cycle", prev_done, 0);
            if (exp_v_q.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               longint ev;
               int k;
               ev = exp_v_q.pop_front();
               k  = exp_k_q.pop_front();
               check("v_uv", bus.v_uv, ev);
               check("v_mv", bus.v_mv, ev / 1000);
               check("latency", cyc - k, 13);
            end
         end else begin
            check("v_hold", bus.v_uv, last_v);
         end
         last_v = bus.v_uv;
         prev_done = bus.done;
      end
   end

   task automatic wait_idle();
      int tmo = 0;
      @(negedge clk);
      while (bus.busy && tmo < 40) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 40) check("idle_timeout", 1, 0);
   endtask

   task automatic drain();
      int tmo = 0;
      while (exp_v_q.size() != 0 && tmo < 40) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 40) check("done_timeout", 1, 0);
      @(negedge clk);
   endtask

   task automatic do_reset();
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      exp_v_q.delete();
      exp_k_q.delete();
      #1;
      check("rst_v_uv", bus.v_uv, -65000);
      check("rst_v_mv", bus.v_mv, -65);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_v = -65000;
   endtask

   task automatic step(input int m, input int h, input int n, input int iext,
                       input int dt, input longint ev);
      wait_idle();
      bus.m = 16'(m); bus.h = 16'(h); bus.n = 16'(n);
      bus.i_ext = 16'(iext); bus.dt = 16'(dt);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      exp_v_q.push_back(ev);
      exp_k_q.push_back(cyc);
      model_v = ev;
      check("busy_after_start", bus.busy, 1);
      bus.m = 16'($urandom); bus.h = 16'($urandom); bus.n = 16'($urandom);
      bus.i_ext = 16'($urandom); bus.dt = 16'($urandom);
   endtask

   task automatic rand_step();
      int m, h, n, iext, dt;
      m = int'($urandom_range(0, 1300)) - 100;
      h = int'($urandom_range(0, 1300)) - 100;
      n = int'($urandom_range(0, 1300)) - 100;
      iext = int'($urandom_range(0, 4000)) - 2000;
      dt = int'($urandom_range(0, 60));
      step(m, h, n, iext, dt, model_step(model_v, m, h, n, iext, dt));
   endtask

   initial begin
      int k0;
      int seen;
      bus.start = 1'b0;
      bus.m = '0; bus.h = '0; bus.n = '0; bus.i_ext = '0; bus.dt = '0;

      do_reset();
      step(53, 596, 318, 0, 10, -65010);
      drain();
      do_reset();
      step(0, 0, 0, 1000, 1000, -51700);
      drain();
      do_reset();
      step(1500, 1000, 0, 0, 1000, 60000);
      drain();
      do_reset();
      step(0, 0, 0, -32768, 65535, -100000);
      drain();

      do_reset();
      for (int i = 0; i < 25; i++) rand_step();
      drain();

      // start held for 20 cycles with dt=0: accepted at k and k+14 only
      wait_idle();
      bus.m = 16'($urandom_range(0, 1000)); bus.h = 16'($urandom_range(0, 1000));
      bus.n = 16'($urandom_range(0, 1000)); bus.i_ext = 16'($urandom_range(0, 2000));
      bus.dt = '0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      k0 = cyc;
      exp_v_q.push_back(model_v); exp_k_q.push_back(k0);
      exp_v_q.push_back(model_v); exp_k_q.push_back(k0 + 14);
      repeat (19) @(posedge clk);
      #1;
      bus.start = 1'b0;
      drain();

      // reset five cycles into a step aborts it without a done pulse
      step(400, 500, 600, 500, 20, model_step(model_v, 400, 500, 600, 500, 20));
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_v_q.delete();
      exp_k_q.delete();
      #1;
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_v_uv", bus.v_uv, -65000);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_v = -65000;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      check("abort_no_done", seen, 0);
      rand_step();
      rand_step();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/hh_membrane_update.md
# hh_membrane_update

Forward-Euler integrator for the Hodgkin-Huxley membrane potential: consumes the m, h, n gating values produced by the gate-update blocks, computes sodium, potassium and leak currents, and produces the next membrane potential V that feeds back to those gate blocks. It uses a start/done handshake and a single shared multiplier sequenced by an FSM, one operation per cycle. All quantities are fixed-point integers. Gates are scaled by 1000 (1000 = 1.0).

## Interface
- G_NA, default 1200, sodium conductance in mS/cm², scaled by 10
- G_K, default 360, potassium conductance in mS/cm², scaled by 10
- G_L, default 3, leak conductance in mS/cm², scaled by 10
- E_NA, default 50, sodium reversal potential in mV
- E_K, default -77, potassium reversal potential in mV
- E_L, default -54, leak reversal potential in mV
- V_REST_UV, default -65000, reset potential in µV
- V_MIN_UV, default -100000, lower clamp in µV
- V_MAX_UV, default 60000, upper clamp in µV
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  request one Euler step; sampled only in IDLE
- m, h, n  in  16 signed each  gate values, scale 1000
- i_ext  in  16 signed  external current in µA/cm², scale 100
- dt  in  16 unsigned  time step in ms, scale 1000
- v_uv  out  32 signed  membrane potential in µV
- v_mv  out  16 signed  v_uv / 1000, truncated toward zero
- busy  out  1  high while a step is in progress
- done  out  1  one-cycle pulse when v_uv/v_mv are updated

## Operation
- Reset: v_uv = V_REST_UV, v_mv = -65, busy = 0, done = 0, FSM = IDLE. All scratch registers are cleared.
- IDLE: when start = 1, latch m, h, n, i_ext, dt and the current v_uv. Clamp each gate to [0, 1000]. Go to M2.
- Intermediate products are 48-bit signed. Every "/" is a signed divide that truncates toward zero.
- Sequence, one state per cycle:
  - M2: p = m·m/1000
  - M3: p = p·m/1000
  - MH: p = p·h/1000
  - NA1: t = p·G_NA
  - NA2: i_na = t·(v − E_NA·1000)/10000
  - N2: q = n·n/1000
  - N4: q = q·q/1000
  - K1: t = q·G_K
  - K2: i_k = t·(v − E_K·1000)/10000
  - L: i_l = G_L·(v − E_L·1000)/10
  - SUM: i_ion = i_na + i_k + i_l (nA/cm²)
  - UPD: dv = (i_ext·10 − i_ion)·dt/1000; v_new = clamp(v + dv, V_MIN_UV, V_MAX_UV)
  - DONE: v_uv = v_new, v_mv = v_new/1000, done = 1; next state IDLE.
- Membrane capacitance is fixed at 1 µF/cm², so no division by C_m is performed.
- start is ignored in every state except IDLE. Inputs may change freely after the start edge.
- dt = 0 still runs the full sequence: v is unchanged and done pulses.

## Timing
- Label the edge that samples start = 1 in IDLE as edge k.
  - busy = 1 after edges k … k+12. It is registered and falls at edge k+13.
  - v_uv, v_mv and done update at edge k+13. done = 1 for exactly one cycle, falling at k+14.
  - Latency from start to done: 13 cycles.
- start high during the DONE cycle is ignored. The earliest next accepted start is at edge k+14; back-to-back throughput is one step per 14 cycles.
- v_uv and v_mv hold their values between done pulses and never change mid-sequence.
- Asserting reset at any point aborts the step immediately: outputs return to their reset values and no done is produced.

## Test plan
- Resting step. m=53, h=596, n=318, i_ext=0, dt=10 from reset.
  - Expect i_na=0, i_k=4320, i_l=−3300, i_ion=1020, dv=−10.
  - v_uv=−65010, v_mv=−65, done exactly 13 cycles after start.
- Depolarising drive. m=h=n=0, i_ext=1000, dt=1000 from reset.
  - Expect i_ion=−3300, v_uv=−51700, v_mv=−51.
- Gate clamp and upper clamp. m=1500 (clamps to 1000), h=1000, n=0, i_ext=0, dt=1000 from reset.
  - Expect i_na=−13800000, v_uv=60000, v_mv=60.
- Lower clamp. m=h=n=0, i_ext=−32768, dt=65535 from reset.
  - Expect v_uv=−100000, v_mv=−100.
- Zero step and ignored start. dt=0 with start held high for 20 cycles.
  - v_uv is unchanged. done pulses at edge k+13 and a second step is accepted at edge k+14.
  - No start is accepted while busy=1.
- Reset mid-step. Assert reset 5 cycles after start.
  - Immediately: busy=0, done=0, v_uv=−65000.
  - No done pulse follows; a new start after reset completes normally.
